// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment demo: segment lookup table and DP threshold.
// Patterns are ordered {A,B,C,D,E,F,G} with a lit segment encoded as 1.
package seven_seg_pkg;

  localparam logic [3:0] DP_THRESHOLD = 4'd10;

  localparam logic [6:0] SEG_LUT [16] = '{
    7'h7E,  // 0
    7'h30,  // 1
    7'h6D,  // 2
    7'h79,  // 3
    7'h33,  // 4
    7'h5B,  // 5
    7'h5F,  // 6
    7'h70,  // 7
    7'h7F,  // 8
    7'h7B,  // 9
    7'h77,  // A
    7'h1F,  // b
    7'h4E,  // C
    7'h3D,  // d
    7'h4F,  // E
    7'h47   // F
  };

  // Every 4-bit code has a table entry, so no blank fallback is needed.
  function automatic logic [6:0] seg_lookup(input logic [3:0] hex);
    return SEG_LUT[hex];
  endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Purely combinational hex digit to active-high segment pattern decoder.
// dp_en flags the letter digits (10-15); the top decides whether to use it.
module hex_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg,
  output logic       dp_en
);

  assign seg   = seg_lookup(hex);
  assign dp_en = (hex >= DP_THRESHOLD);

endmodule

// File: rtl/seven_seg_top.sv
// Top level of the icoboard seven-segment demo: decode, polarity and output registers.
// RST blanks the digit at the unlit level of the selected polarity.
module seven_seg_top
  import seven_seg_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b0,
  parameter bit DP_ON_HEX  = 1'b0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] IN,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  output logic       E,
  output logic       F,
  output logic       G,
  output logic       DP
);

  logic [6:0] seg_s;
  logic       dp_en_s;
  logic       dp_lit_s;
  logic [6:0] seg_next_s;
  logic       dp_next_s;
  logic [6:0] seg_blank_s;
  logic       dp_blank_s;
  logic [6:0] seg_r;
  logic       dp_r;

  hex_to_seg u_hex_to_seg (
    .hex   (IN),
    .seg   (seg_s),
    .dp_en (dp_en_s)
  );

  assign dp_lit_s = DP_ON_HEX & dp_en_s;

  // Apply output polarity to the decoded pattern and the blank level.
  always_comb begin
    seg_next_s  = seg_s;
    dp_next_s   = dp_lit_s;
    seg_blank_s = 7'h00;
    dp_blank_s  = 1'b0;
    if (ACTIVE_LOW) begin
      seg_next_s  = ~seg_s;
      dp_next_s   = ~dp_lit_s;
      seg_blank_s = 7'h7F;
      dp_blank_s  = 1'b1;
    end else begin
      seg_next_s  = seg_s;
      dp_next_s   = dp_lit_s;
      seg_blank_s = 7'h00;
      dp_blank_s  = 1'b0;
    end
  end

  // Output registers; reset wins over any IN value.
  always_ff @(posedge CLK) begin
    if (RST) begin
      seg_r <= seg_blank_s;
      dp_r  <= dp_blank_s;
    end else begin
      seg_r <= seg_next_s;
      dp_r  <= dp_next_s;
    end
  end

  assign {A, B, C, D, E, F, G} = seg_r;
  assign DP                    = dp_r;

endmodule

// File: tb/tb_seven_seg_top.sv
// Self-checking bench for seven_seg_top: three parameterisations share IN/RST.
// Outputs are packed {A,B,C,D,E,F,G,DP} and sampled on the falling clock edge.
`timescale 1ns/100ps
module tb_seven_seg_top;

  typedef struct {
    logic [3:0] in;
    logic [6:0] seg;
    logic       dp_hex;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [3:0] in_val;
  logic [7:0] out_def;
  logic [7:0] out_dp;
  logic [7:0] out_al;

  int n_cmp;
  int n_bad;

  vec_t vec [16];

  seven_seg_top #(.ACTIVE_LOW(1'b0), .DP_ON_HEX(1'b0)) u_def (
    .CLK(clk), .RST(rst), .IN(in_val),
    .A(out_def[7]), .B(out_def[6]), .C(out_def[5]), .D(out_def[4]),
    .E(out_def[3]), .F(out_def[2]), .G(out_def[1]), .DP(out_def[0])
  );

  seven_seg_top #(.ACTIVE_LOW(1'b0), .DP_ON_HEX(1'b1)) u_dp (
    .CLK(clk), .RST(rst), .IN(in_val),
    .A(out_dp[7]), .B(out_dp[6]), .C(out_dp[5]), .D(out_dp[4]),
    .E(out_dp[3]), .F(out_dp[2]), .G(out_dp[1]), .DP(out_dp[0])
  );

  seven_seg_top #(.ACTIVE_LOW(1'b1), .DP_ON_HEX(1'b0)) u_al (
    .CLK(clk), .RST(rst), .IN(in_val),
    .A(out_al[7]), .B(out_al[6]), .C(out_al[5]), .D(out_al[4]),
    .E(out_al[3]), .F(out_al[2]), .G(out_al[1]), .DP(out_al[0])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %02h expected %02h", name, got, exp);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    rst    = 1'b1;
    in_val = 4'h8;

    vec[0]  = '{4'h0, 7'h7E, 1'b0};
    vec[1]  = '{4'h1, 7'h30, 1'b0};
    vec[2]  = '{4'h2, 7'h6D, 1'b0};
    vec[3]  = '{4'h3, 7'h79, 1'b0};
    vec[4]  = '{4'h4, 7'h33, 1'b0};
    vec[5]  = '{4'h5, 7'h5B, 1'b0};
    vec[6]  = '{4'h6, 7'h5F, 1'b0};
    vec[7]  = '{4'h7, 7'h70, 1'b0};
    vec[8]  = '{4'h8, 7'h7F, 1'b0};
    vec[9]  = '{4'h9, 7'h7B, 1'b0};
    vec[10] = '{4'hA, 7'h77, 1'b1};
    vec[11] = '{4'hB, 7'h1F, 1'b1};
    vec[12] = '{4'hC, 7'h4E, 1'b1};
    vec[13] = '{4'hD, 7'h3D, 1'b1};
    vec[14] = '{4'hE, 7'h4F, 1'b1};
    vec[15] = '{4'hF, 7'h47, 1'b1};

    // Reset held for three edges with IN=8: every output unlit.
    repeat (3) @(negedge clk);
    check("rst_def", out_def, 8'h00);
    check("rst_dp",  out_dp,  8'h00);
    check("rst_al",  out_al,  8'hFF);

    rst = 1'b0;
    @(negedge clk);
    check("rel_def", out_def, 8'hFE);
    check("rel_dp",  out_dp,  8'hFE);
    check("rel_al",  out_al,  8'h01);

    // Sweep 0..15, one value per cycle, one cycle latency.
    for (int i = 0; i < 16; i++) begin
      in_val = vec[i].in;
      @(negedge clk);
      check($sformatf("sweep_def_%0d", i), out_def, {vec[i].seg, 1'b0});
      check($sformatf("sweep_dp_%0d", i),  out_dp,  {vec[i].seg, vec[i].dp_hex});
      check($sformatf("sweep_al_%0d", i),  out_al,  {~vec[i].seg, 1'b1});
    end

    // Active-low digit 1, then reset drives all eight outputs high.
    in_val = 4'h1;
    @(negedge clk);
    check("al_one", out_al, 8'h9F);
    rst = 1'b1;
    @(negedge clk);
    check("al_rst", out_al, 8'hFF);
    rst = 1'b0;

    // IN changes 3->4 just before an edge: old value holds until that edge.
    in_val = 4'h3;
    @(negedge clk);
    check("chg_three", out_def, 8'hF2);
    #3;
    in_val = 4'h4;
    #1;
    check("chg_hold", out_def, 8'hF2);
    @(posedge clk);
    #1;
    check("chg_four", out_def, 8'h66);
    @(negedge clk);

    // One-cycle reset mid-sweep at IN=7: blank, then IN shown again.
    in_val = 4'h6;
    @(negedge clk);
    check("mid_six", out_def, 8'hBE);
    in_val = 4'h7;
    rst    = 1'b1;
    @(negedge clk);
    check("mid_rst", out_def, 8'h00);
    check("mid_rst_al", out_al, 8'hFF);
    rst = 1'b0;
    @(negedge clk);
    check("mid_seven", out_def, 8'hE0);
    in_val = 4'h8;
    @(negedge clk);
    check("mid_eight", out_def, 8'hFE);

    // IN changes while reset is held are ignored.
    rst    = 1'b1;
    in_val = 4'hA;
    @(negedge clk);
    in_val = 4'h2;
    @(negedge clk);
    check("rst_ign_dp", out_dp, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    check("rst_exit_dp", out_dp, 8'hDA);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
